// File: rtl/approx_mult_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_mult_err_monitor
//
// Accuracy monitor for an approximate WxW multiplier. Each accepted sample
// carries two operands plus the product the approximate multiplier returned.
// The monitor rebuilds the exact product with a shift-add loop (one operand
// bit per cycle), takes the absolute error against the approximate product
// and folds it into running statistics.
//
// Parameters:
//   W      operand width (product width is 2W)
//   CNT_W  width of sample_count / match_count
//   ACC_W  width of err_sum (must be at least 2W)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   in_valid       sample offered
//   in_ready       monitor idle and able to take a sample
//   in_a, in_x     operands (unsigned)
//   in_product     approximate product under test
//   clear          synchronous statistics clear, also aborts an in-flight sample
//   result_valid   one-cycle pulse per completed sample
//   exact_product  exact A*X of the last completed sample
//   abs_err        |exact - approximate| of the last completed sample
//   sample_count   completed samples (saturating)
//   match_count    samples with zero error (saturating)
//   err_sum        sum of abs_err (saturating)
//   err_max        largest abs_err seen
//
// Build option:
//   ERR_MON_MAX_TRACK_EN  when defined, err_max tracking is compiled in;
//                         otherwise err_max is tied to zero.
// ---------------------------------------------------------------------------
module approx_mult_err_monitor #(
   parameter int W     = 16,
   parameter int CNT_W = 32,
   parameter int ACC_W = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_x,
   input  logic [2*W-1:0]     in_product,
   input  logic               clear,
   output logic               result_valid,
   output logic [2*W-1:0]     exact_product,
   output logic [2*W-1:0]     abs_err,
   output logic [CNT_W-1:0]   sample_count,
   output logic [CNT_W-1:0]   match_count,
   output logic [ACC_W-1:0]   err_sum,
   output logic [2*W-1:0]     err_max
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      CMP
   } state_t;

   state_t            state;
   logic [2*W-1:0]    a_sh;
   logic [W-1:0]      x_sh;
   logic [2*W-1:0]    acc;
   logic [2*W-1:0]    approx;
   logic [CW-1:0]     bit_cnt;

   logic              handshake;
   logic [2*W:0]      diff;
   logic [2*W-1:0]    mag;
   logic [ACC_W:0]    sum_ext;

   // The monitor only takes a sample while idle; clear (and reset) hold the
   // door shut so that a clear arriving with a sample always wins.
   assign in_ready  = (state == IDLE) && !clear && !rst;
   assign handshake = in_valid && in_ready;

   // Error magnitude: an extra top bit on the difference acts as the sign,
   // so the two's-complement negate below can never wrap. The saturating
   // error sum uses one spare bit to detect overflow of err_sum.
   always_comb begin
      diff    = {1'b0, acc} - {1'b0, approx};
      mag     = diff[2*W] ? (~diff[2*W-1:0] + 1'b1) : diff[2*W-1:0];
      sum_ext = {1'b0, err_sum} + {{(ACC_W + 1 - 2*W){1'b0}}, mag};
   end

   // Control FSM and shift-add datapath. Operands are captured only on the
   // handshake edge; after that the input pins are ignored. MUL consumes one
   // bit of X per cycle, adding the progressively left-shifted A into the
   // accumulator, and hands over to CMP after W iterations. A clear during
   // MUL or CMP simply drops the sample by returning to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_sh    <= '0;
         x_sh    <= '0;
         acc     <= '0;
         approx  <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  a_sh    <= {{W{1'b0}}, in_a};
                  x_sh    <= in_x;
                  approx  <= in_product;
                  acc     <= '0;
                  bit_cnt <= '0;
                  state   <= MUL;
               end
            end
            MUL: begin
               if (clear) begin
                  state <= IDLE;
               end else begin
                  if (x_sh[0]) begin
                     acc <= acc + a_sh;
                  end
                  x_sh    <= x_sh >> 1;
                  a_sh    <= a_sh << 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= CMP;
                  end
               end
            end
            CMP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Result registers and statistics. The edge that ends CMP publishes the
   // exact product and error, pulses result_valid and folds the error into
   // the counters. Counters and the error sum stick at all-ones instead of
   // wrapping. A clear zeroes the statistics but leaves the last published
   // exact_product / abs_err untouched; only reset clears those.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_valid  <= 1'b0;
         exact_product <= '0;
         abs_err       <= '0;
         sample_count  <= '0;
         match_count   <= '0;
         err_sum       <= '0;
      end else begin
         result_valid <= 1'b0;
         if (clear) begin
            sample_count <= '0;
            match_count  <= '0;
            err_sum      <= '0;
         end else if (state == CMP) begin
            result_valid  <= 1'b1;
            exact_product <= acc;
            abs_err       <= mag;
            if (sample_count != '1) begin
               sample_count <= sample_count + 1'b1;
            end
            if ((mag == '0) && (match_count != '1)) begin
               match_count <= match_count + 1'b1;
            end
            if (sum_ext[ACC_W]) begin
               err_sum <= '1;
            end else begin
               err_sum <= sum_ext[ACC_W-1:0];
            end
         end
      end
   end

`ifdef ERR_MON_MAX_TRACK_EN
   // Peak error tracker, updated on the same edge as the other statistics.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_max <= '0;
      end else if ((state == CMP) && (mag > err_max)) begin
         err_max <= mag;
      end
   end
`else
   // Peak tracking not built: the output reads as a constant zero.
   assign err_max = '0;
`endif

endmodule
